// File: rtl/memcfg_issue.sv
// memcfg_issue: bus-initiator side of the memory configuration command.
// It takes a page->frame request from the CPU sequencer, presents page/frame with ad15
// on the bus, strobes s_ (active-low) and completes a four-phase handshake with cok.
// A single done pulse reports the result: ok if a module answered, nok otherwise.
// Page and frame use the bus's [0:7] numbering; here they are carried as plain 8-bit values.
// Optional feature macro: MEMCFG_RETRY_EN. When it is defined, a strobe timeout triggers one
// repeat of the command with the same page/frame. When it is undefined, the first timeout
// ends the command with nok.
// The FSM state is exported on state_o so that checkers can bind to it.
// Handshake: s_ falls only after the SETUP hold and rises only on leaving STROBE.
// cok is sampled high to end the strobe and sampled low to end the release.
// The timer is shared by SETUP, STROBE and RELEASE, and restarts on every state change.
// The timer is sized for TIMEOUT, so SETUP must not exceed TIMEOUT.

module memcfg_issue #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned SETUP   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] req_page,
  input  logic [7:0] req_frame,
  output logic       busy,
  output logic       done,
  output logic       ok,
  output logic       nok,
  output logic       s_,
  output logic       ad15,
  output logic [7:0] cfg_page,
  output logic [7:0] cfg_frame,
  input  logic       cok,
  output logic [2:0] state_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          s_q, s_d;
  logic          ad15_q, ad15_d;
  logic [7:0]    page_q, page_d;
  logic [7:0]    frame_q, frame_d;
  logic          res_ok_q, res_ok_d;
`ifdef MEMCFG_RETRY_EN
  logic          retry_q, retry_d;
`endif

  // Next-state logic: bus strobe sequencing, the result flag and the per-state timer.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    ad15_d   = ad15_q;
    page_d   = page_q;
    frame_d  = frame_q;
    res_ok_d = res_ok_q;
`ifdef MEMCFG_RETRY_EN
    retry_d  = retry_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef MEMCFG_RETRY_EN
        retry_d = 1'b0;
`endif
        if (start) begin
          res_ok_d = 1'b0;
          if (req_page > 8'd1) begin
            page_d  = req_page;
            frame_d = req_frame;
            ad15_d  = 1'b1;
            state_d = ST_SETUP;
          end else begin
            // Pages 0 and 1 are hard-wired: reject without touching the bus.
            state_d = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        if (timer_q == SETUP_LAST) begin
          s_d     = 1'b0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        // cok takes priority over a timeout that expires in the same cycle.
        if (cok) begin
          s_d      = 1'b1;
          res_ok_d = 1'b1;
          state_d  = ST_RELEASE;
        end else if (timer_q == TO_LAST) begin
          s_d      = 1'b1;
          res_ok_d = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!cok) begin
`ifdef MEMCFG_RETRY_EN
          // Only a strobe timeout leaves res_ok clear here; such a timeout earns one retry.
          if (!res_ok_q && !retry_q) begin
            retry_d = 1'b1;
            state_d = ST_SETUP;
          end else begin
            ad15_d  = 1'b0;
            state_d = ST_DONE;
          end
`else
          ad15_d  = 1'b0;
          state_d = ST_DONE;
`endif
        end else if (timer_q == TO_LAST) begin
          // The module never released cok: drop the command and report failure.
          ad15_d   = 1'b0;
          res_ok_d = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // State and bus registers. An asynchronous reset frees the bus at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      s_q      <= 1'b1;
      ad15_q   <= 1'b0;
      page_q   <= 8'h00;
      frame_q  <= 8'h00;
      res_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      s_q      <= s_d;
      ad15_q   <= ad15_d;
      page_q   <= page_d;
      frame_q  <= frame_d;
      res_ok_q <= res_ok_d;
    end
  end

`ifdef MEMCFG_RETRY_EN
  // One-shot retry marker, cleared when the FSM is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // Status outputs are decoded from registered state, so they cannot glitch.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    ok        = done & res_ok_q;
    nok       = done & ~res_ok_q;
    s_        = s_q;
    ad15      = ad15_q;
    cfg_page  = page_q;
    cfg_frame = frame_q;
    state_o   = state_q;
  end

endmodule

// File: tb/tb_memcfg_issue.sv
// tb_memcfg_issue: directed and randomized configuration commands against memcfg_issue.
// The bench acts as the memory module and drives cok from the s_ that it observes.
// For each command the bench computes the expected strobe length, done cycle and result
// from the command's timing rules, using counts of cycles.
module tb_memcfg_issue;

  localparam int TIMEOUT = 16;
  localparam int SETUP   = 1;
  localparam int BUDGET  = 80;

  logic       clk = 1'b0;
  logic       reset, start, cok;
  logic [7:0] req_page, req_frame;
  logic       busy, done, ok, nok, s_, ad15;
  logic [7:0] cfg_page, cfg_frame;
  logic [2:0] dut_state;

  int checks   = 0;
  int failures = 0;
  // Expected {ok, nok} for each issued command, popped when its done pulse arrives.
  logic [1:0] exp_q[$];

  memcfg_issue #(.TIMEOUT(TIMEOUT), .SETUP(SETUP)) dut (
    .clk(clk), .reset(reset), .start(start), .req_page(req_page), .req_frame(req_frame),
    .busy(busy), .done(done), .ok(ok), .nok(nok), .s_(s_), .ad15(ad15),
    .cfg_page(cfg_page), .cfg_frame(cfg_frame), .cok(cok), .state_o(dut_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and act as the module.
  // ack_dly is the number of s_-low cycles before cok rises; -1 means cok never rises.
  // hold is the number of cycles that cok stays high after s_ rises.
  // spur is the cycle in which a second start (page 8'h20) is pulsed; -1 means none.
  task automatic run_txn(input logic [7:0] pg, input logic [7:0] fr,
                         input int ack_dly, input int hold, input int spur);
    int exp_low, exp_rel, exp_done;
    logic exp_ok;
    int low_cnt, hi_cnt, done_at, busy_bad, ad15_bad, ad15_seen;
    logic seen_low, acked;
    logic [1:0] got;
    if (pg <= 8'd1) begin
      exp_low = 0; exp_rel = 0; exp_ok = 1'b0; exp_done = 1;
    end else begin
      if (ack_dly < 0 || ack_dly >= TIMEOUT) begin
        exp_low = TIMEOUT; exp_rel = 1; exp_ok = 1'b0;
      end else begin
        exp_low = ack_dly + 1;
        if (hold >= TIMEOUT) begin exp_rel = TIMEOUT; exp_ok = 1'b0; end
        else begin exp_rel = hold + 1; exp_ok = 1'b1; end
      end
      exp_done = 1 + SETUP + exp_low + exp_rel;
    end
    exp_q.push_back({exp_ok, ~exp_ok});

    @(posedge clk); #1;
    start = 1'b1; req_page = pg; req_frame = fr; cok = 1'b0;
    low_cnt = 0; hi_cnt = 0; done_at = -1; busy_bad = 0; ad15_bad = 0; ad15_seen = 0;
    seen_low = 1'b0; acked = 1'b0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == spur) begin
        start = 1'b1; req_page = 8'h20; req_frame = 8'(($urandom));
      end
      if (ad15) ad15_seen++;
      if (!s_) begin
        low_cnt++;
        seen_low = 1'b1;
        if (!ad15) ad15_bad++;
        if (low_cnt == 1) begin
          chk("cfg_page_at_strobe", 32'(cfg_page), 32'(pg));
          chk("cfg_frame_at_strobe", 32'(cfg_frame), 32'(fr));
        end
      end else if (seen_low) begin
        hi_cnt++;
      end
      if (done_at < 0 && !busy) busy_bad++;
      if (done_at >= 0 && n == done_at + 1) begin
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("single_done", 32'(done), 32'd0);
        break;
      end
      if (done && done_at < 0) begin
        done_at = n;
        got = exp_q.pop_front();
        chk("done_cycle", done_at, exp_done);
        chk("ok", 32'(ok), 32'(got[1]));
        chk("nok", 32'(nok), 32'(got[0]));
        chk("s_at_done", 32'(s_), 32'd1);
        chk("ad15_at_done", 32'(ad15), 32'd0);
        if (pg > 8'd1) chk("cfg_page_kept", 32'(cfg_page), 32'(pg));
      end
      // Module behaviour for the next cycle.
      if (done_at >= 0) cok = 1'b0;
      else if (!s_) begin
        cok = (ack_dly >= 0) && (low_cnt > ack_dly);
        if (cok) acked = 1'b1;
      end else if (seen_low) cok = acked && (hi_cnt <= hold);
      else cok = 1'b0;
    end
    start = 1'b0; cok = 1'b0;
    if (done_at < 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    chk("s_low_cycles", low_cnt, exp_low);
    chk("ad15_during_strobe", ad15_bad, 0);
    chk("busy_until_done", busy_bad, 0);
    if (pg <= 8'd1) chk("ad15_untouched", ad15_seen, 0);
  endtask

  initial begin
    int wait_n;
    reset = 1'b1; start = 1'b0; cok = 1'b0; req_page = 8'h00; req_frame = 8'h00;
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_", 32'(s_), 32'd1);
    chk("rst_ad15", 32'(ad15), 32'd0);
    chk("rst_cfg", {16'd0, cfg_page, cfg_frame}, 32'd0);
    chk("rst_status", {28'd0, busy, done, ok, nok}, 32'd0);
    reset = 1'b0;

    // Directed commands.
    run_txn(8'h05, 8'h23, 1, 1, -1);           // normal handshake
    run_txn(8'h01, 8'h44, 0, 0, -1);           // fixed page rejected
    run_txn(8'h00, 8'h44, 0, 0, -1);
    run_txn(8'h10, 8'h11, -1, 0, -1);          // no answer
    run_txn(8'h05, 8'h23, 0, 20, -1);          // cok stuck after ack
    run_txn(8'h05, 8'h23, 4, 0, 4);            // second start during STROBE ignored
    run_txn(8'h02, 8'hff, 0, 0, -1);           // immediate cok, smallest mapped page
    run_txn(8'hff, 8'h00, 15, 0, -1);          // ack in the last strobe cycle
    run_txn(8'h80, 8'h5a, 0, 15, -1);          // release in the last allowed cycle

    // Reset during STROBE.
    @(posedge clk); #1;
    start = 1'b1; req_page = 8'h05; req_frame = 8'h23;
    @(posedge clk); #1;
    start = 1'b0;
    wait_n = 0;
    while (s_ && wait_n < 10) begin @(posedge clk); #1; wait_n++; end
    chk("strobe_before_reset", 32'(s_), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_s_", 32'(s_), 32'd1);
    chk("rst_mid_ad15", 32'(ad15), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) wait_n++;
    end
    chk("rst_no_done", wait_n, 0);
    run_txn(8'h07, 8'h31, 2, 2, -1);

    // Randomized commands.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] pg;
      int ad, hd, sp;
      pg = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
      ad = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 2));
      hd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TIMEOUT, TIMEOUT + 3))
                                       : int'($urandom_range(0, 4));
      sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : -1;
      if (pg <= 8'd1) sp = -1;
      run_txn(pg, 8'($urandom), ad, hd, sp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
